// File: rtl/clock_pkg.sv
// Shared types and constants for the time counter and its sequencing controller.
package clock_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        COMMIT   = 2'd3
    } clk_ctrl_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    function automatic logic [HR_W-1:0] incWrapHr(input logic [HR_W-1:0] value);
        return (value == MAX_HR) ? '0 : value + HR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] incWrapMin(input logic [MIN_W-1:0] value);
        return (value == MAX_MIN) ? '0 : value + MIN_W'(1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every DIV enabled cycles;
// the count is held at zero whenever the enable is low.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (en && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-set controller: 1 Hz count enable plus a two-button hour/minute edit
// sequence that ends with a single-cycle parallel load into the counter.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = TICK_DIV / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    output logic             sec_tick,
    output logic             run_en,
    output logic             ld,
    output logic [HR_W-1:0]  ld_hr,
    output logic [MIN_W-1:0] ld_min,
    output logic [MIN_W-1:0] ld_sec,
    output logic [1:0]       edit_field,
    output logic             blink
);

    clk_ctrl_state_t state_q, state_d;

    logic             modeBtn_q;
    logic             incBtn_q;
    logic [HR_W-1:0]  hrShadow_q,  hrShadow_d;
    logic [MIN_W-1:0] minShadow_q, minShadow_d;
    logic             blink_q,     blink_d;

    logic modeRise;
    logic incRise;
    logic inEdit;
    logic inEditNext;
    logic blinkTick;

    assign modeRise   = btn_mode & ~modeBtn_q;
    assign incRise    = btn_inc  & ~incBtn_q;
    assign inEdit     = (state_q == EDIT_HR) || (state_q == EDIT_MIN);
    assign inEditNext = (state_d == EDIT_HR) || (state_d == EDIT_MIN);

    // Prescalers are enabled from registered state only, keeping buttons off the output paths.
    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_secPrescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == RUN),
        .tick (sec_tick)
    );

    tick_prescaler #(
        .DIV (BLINK_DIV)
    ) u_blinkPrescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (inEdit),
        .tick (blinkTick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            modeBtn_q   <= 1'b0;
            incBtn_q    <= 1'b0;
            hrShadow_q  <= '0;
            minShadow_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            modeBtn_q   <= btn_mode;
            incBtn_q    <= btn_inc;
            hrShadow_q  <= hrShadow_d;
            minShadow_q <= minShadow_d;
            blink_q     <= blink_d;
        end
    end

    // A simultaneous mode+inc rise aborts an edit; in RUN it counts as mode only.
    always_comb begin
        state_d     = state_q;
        hrShadow_d  = hrShadow_q;
        minShadow_d = minShadow_q;
        unique case (state_q)
            RUN: begin
                if (modeRise) begin
                    state_d     = EDIT_HR;
                    hrShadow_d  = cur_hr;
                    minShadow_d = cur_min;
                end
            end
            EDIT_HR: begin
                if (modeRise && incRise) begin
                    state_d = RUN;
                end else if (incRise) begin
                    hrShadow_d = incWrapHr(hrShadow_q);
                end else if (modeRise) begin
                    state_d = EDIT_MIN;
                end
            end
            EDIT_MIN: begin
                if (modeRise && incRise) begin
                    state_d = RUN;
                end else if (incRise) begin
                    minShadow_d = incWrapMin(minShadow_q);
                end else if (modeRise) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Blink phase survives EDIT_HR -> EDIT_MIN but is cleared whenever editing ends.
    always_comb begin
        blink_d = 1'b0;
        if (inEditNext) begin
            blink_d = blink_q ^ blinkTick;
        end
    end

    always_comb begin
        run_en     = 1'b0;
        ld         = 1'b0;
        edit_field = FIELD_NONE;
        unique case (state_q)
            RUN:      run_en     = 1'b1;
            EDIT_HR:  edit_field = FIELD_HR;
            EDIT_MIN: edit_field = FIELD_MIN;
            COMMIT:   ld         = 1'b1;
            default:  run_en     = 1'b0;
        endcase
    end

    assign ld_hr  = hrShadow_q;
    assign ld_min = minShadow_q;
    assign ld_sec = '0;
    assign blink  = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICK_DIV = 4 and BLINK_DIV = 2.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hr = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic       sec_tick;
    logic       run_en;
    logic       ld;
    logic [4:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic [1:0] edit_field;
    logic       blink;

    int errors = 0;
    int checks = 0;
    int ldSeen = 0;
    int tickSeen = 0;
    int ldBase;
    int tickBase;

    clock_time_ctrl #(
        .TICK_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .sec_tick   (sec_tick),
        .run_en     (run_en),
        .ld         (ld),
        .ld_hr      (ld_hr),
        .ld_min     (ld_min),
        .ld_sec     (ld_sec),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    // Running tallies of load strobes and second ticks, sampled mid-cycle.
    always @(negedge clk) begin
        if (ld) ldSeen = ldSeen + 1;
        if (sec_tick) tickSeen = tickSeen + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One press: buttons high across one rising edge, then released for one cycle.
    task automatic applyStimulus(input logic modeLvl, input logic incLvl);
        btn_mode = modeLvl;
        btn_inc  = incLvl;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;

        checkOutput("rst_sec_tick", 32'(sec_tick), 32'd0);
        checkOutput("rst_ld", 32'(ld), 32'd0);
        checkOutput("rst_blink", 32'(blink), 32'd0);
        checkOutput("rst_edit_field", 32'(edit_field), 32'd0);
        checkOutput("rst_run_en", 32'(run_en), 32'd1);
        checkOutput("rst_ld_hr", 32'(ld_hr), 32'd0);
        checkOutput("rst_ld_min", 32'(ld_min), 32'd0);
        checkOutput("rst_ld_sec", 32'(ld_sec), 32'd0);

        for (int c = 1; c <= 12; c++) begin
            checkOutput("idle_sec_tick", 32'(sec_tick), 32'((c % 4) == 0));
            checkOutput("idle_run_en", 32'(run_en), 32'd1);
            checkOutput("idle_ld", 32'(ld), 32'd0);
            step();
        end

        // Full edit with both fields wrapping: 22->23->0 and 58->59->0.
        cur_hr   = 5'd22;
        cur_min  = 6'd58;
        ldBase   = ldSeen;
        tickBase = tickSeen;
        applyStimulus(1'b1, 1'b0);
        checkOutput("edit_hr_field", 32'(edit_field), 32'd1);
        checkOutput("edit_hr_run_en", 32'(run_en), 32'd0);
        checkOutput("capture_hr", 32'(ld_hr), 32'd22);
        checkOutput("capture_min", 32'(ld_min), 32'd58);
        applyStimulus(1'b0, 1'b1);
        checkOutput("hr_inc_23", 32'(ld_hr), 32'd23);
        applyStimulus(1'b0, 1'b1);
        checkOutput("hr_wrap_0", 32'(ld_hr), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("edit_min_field", 32'(edit_field), 32'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("min_inc_59", 32'(ld_min), 32'd59);
        applyStimulus(1'b0, 1'b1);
        checkOutput("min_wrap_0", 32'(ld_min), 32'd0);
        checkOutput("hr_kept_in_min", 32'(ld_hr), 32'd0);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        checkOutput("commit_ld", 32'(ld), 32'd1);
        checkOutput("commit_ld_hr", 32'(ld_hr), 32'd0);
        checkOutput("commit_ld_min", 32'(ld_min), 32'd0);
        checkOutput("commit_ld_sec", 32'(ld_sec), 32'd0);
        checkOutput("commit_sec_tick", 32'(sec_tick), 32'd0);
        checkOutput("commit_run_en", 32'(run_en), 32'd0);
        step();
        checkOutput("post_commit_run_en", 32'(run_en), 32'd1);
        checkOutput("post_commit_ld", 32'(ld), 32'd0);
        step();
        step();
        checkOutput("post_commit_tick_3", 32'(sec_tick), 32'd0);
        checkOutput("ticks_during_edit", 32'(tickSeen - tickBase), 32'd0);
        checkOutput("ld_pulse_count", 32'(ldSeen - ldBase), 32'd1);
        step();
        checkOutput("post_commit_tick_4", 32'(sec_tick), 32'd1);

        // Holding inc must give exactly one increment.
        cur_hr  = 5'd5;
        cur_min = 6'd30;
        applyStimulus(1'b1, 1'b0);
        checkOutput("capture_hr_5", 32'(ld_hr), 32'd5);
        btn_inc = 1'b1;
        repeat (10) step();
        btn_inc = 1'b0;
        step();
        checkOutput("held_inc_hr", 32'(ld_hr), 32'd6);
        checkOutput("held_inc_field", 32'(edit_field), 32'd1);

        // Abort from EDIT_MIN: no load, shadows untouched, ticks restart from zero.
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_pre_field", 32'(edit_field), 32'd2);
        ldBase   = ldSeen;
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        checkOutput("abort_field", 32'(edit_field), 32'd0);
        checkOutput("abort_run_en", 32'(run_en), 32'd1);
        checkOutput("abort_ld", 32'(ld), 32'd0);
        checkOutput("abort_tick_1", 32'(sec_tick), 32'd0);
        step();
        step();
        checkOutput("abort_tick_3", 32'(sec_tick), 32'd0);
        step();
        checkOutput("abort_tick_4", 32'(sec_tick), 32'd1);
        checkOutput("abort_ld_hr", 32'(ld_hr), 32'd6);
        checkOutput("abort_ld_min", 32'(ld_min), 32'd30);
        checkOutput("abort_no_ld", 32'(ldSeen - ldBase), 32'd0);

        // Blink phase in EDIT_HR, carried across the move to EDIT_MIN.
        checkOutput("run_blink", 32'(blink), 32'd0);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        checkOutput("blink_field_hr", 32'(edit_field), 32'd1);
        for (int k = 0; k < 7; k++) begin
            checkOutput("blink_hr", 32'(blink), 32'((k / 2) % 2));
            if (k < 6) step();
        end
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        checkOutput("blink_field_min", 32'(edit_field), 32'd2);
        checkOutput("blink_min_keep", 32'(blink), 32'd1);
        step();
        checkOutput("blink_min_toggle", 32'(blink), 32'd0);
        step();
        checkOutput("blink_min_hold", 32'(blink), 32'd0);
        step();
        checkOutput("blink_min_toggle2", 32'(blink), 32'd1);

        // Asynchronous reset between edges while in EDIT_MIN.
        ldBase = ldSeen;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_field", 32'(edit_field), 32'd0);
        checkOutput("async_rst_blink", 32'(blink), 32'd0);
        checkOutput("async_rst_run_en", 32'(run_en), 32'd1);
        checkOutput("async_rst_ld", 32'(ld), 32'd0);
        checkOutput("async_rst_ld_hr", 32'(ld_hr), 32'd0);
        checkOutput("async_rst_ld_min", 32'(ld_min), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        checkOutput("post_rst_tick_3", 32'(sec_tick), 32'd0);
        step();
        checkOutput("post_rst_tick_4", 32'(sec_tick), 32'd1);
        checkOutput("post_rst_no_ld", 32'(ldSeen - ldBase), 32'd0);
        checkOutput("post_rst_field", 32'(edit_field), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
